// File: rtl/core_mem_arbiter_if.sv
// Requester and memory-port signal bundle for core_mem_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface core_mem_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req_val;
  logic [N_REQ-1:0]    req_wen;
  logic [8*N_REQ-1:0]  req_addr;
  logic [16*N_REQ-1:0] req_wdata;
  logic [N_REQ-1:0]    req_rdy;
  logic [15:0]         req_rdata;
  logic                mem_val;
  logic                mem_wen;
  logic [7:0]          mem_addr;
  logic [15:0]         mem_wdata;
  logic                mem_rdy;
  logic [15:0]         mem_rdata;

  modport slave (
    input  req_val, req_wen, req_addr, req_wdata, mem_rdy, mem_rdata,
    output req_rdy, req_rdata, mem_val, mem_wen, mem_addr, mem_wdata
  );

  modport master (
    output req_val, req_wen, req_addr, req_wdata, mem_rdy, mem_rdata,
    input  req_rdy, req_rdata, mem_val, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter sharing one memory RW port among N_REQ requesters.
// Optional macro CORE_MEM_ARB_FIXED_PRIO_EN: requester 0 always wins when requesting.
module core_mem_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  core_mem_arbiter_if.slave     bus,
  output logic                  busy_o,
  output logic [IDX_W-1:0]      grant_o
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;

  logic [N_REQ-1:0]  req_rdy;
  logic [15:0]       req_rdata;
  logic              mem_val;
  logic              mem_wen;
  logic [7:0]        mem_addr;
  logic [15:0]       mem_wdata;

  // Rotating search from rr_ptr; in fixed-priority builds requester 0 is taken out
  // of the rotation and checked first.
  always_comb begin
    int k;
    pick_found = 1'b0;
    pick_idx   = '0;
    k          = 0;
`ifdef CORE_MEM_ARB_FIXED_PRIO_EN
    if (bus.req_val[0]) begin
      pick_found = 1'b1;
    end
`endif
    for (int i = 0; i < N_REQ; i++) begin
      k = int'(rr_ptr_q) + i;
      if (k >= N_REQ) k = k - N_REQ;
`ifdef CORE_MEM_ARB_FIXED_PRIO_EN
      if (!pick_found && bus.req_val[k] && (k != 0)) begin
`else
      if (!pick_found && bus.req_val[k]) begin
`endif
        pick_found = 1'b1;
        pick_idx   = IDX_W'(k);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    req_rdy   = '0;
    req_rdata = '0;
    mem_val   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        mem_val   = 1'b1;
        mem_wen   = bus.req_wen[grant_q];
        mem_addr  = bus.req_addr[8*int'(grant_q) +: 8];
        mem_wdata = bus.req_wdata[16*int'(grant_q) +: 16];
        // A reset in the completion cycle drops the transaction without a strobe.
        if (bus.mem_rdy && !rst_i) begin
          req_rdy[grant_q] = 1'b1;
          req_rdata        = bus.mem_rdata;
          state_d          = IDLE;
`ifdef CORE_MEM_ARB_FIXED_PRIO_EN
          if (grant_q != '0) begin
            rr_ptr_d = (grant_q == IDX_W'(N_REQ-1)) ? '0 : grant_q + 1'b1;
          end
`else
          rr_ptr_d = (grant_q == IDX_W'(N_REQ-1)) ? '0 : grant_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.req_rdy   = req_rdy;
  assign bus.req_rdata = req_rdata;
  assign bus.mem_val   = mem_val;
  assign bus.mem_wen   = mem_wen;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign busy_o        = (state_q == BUSY);
  assign grant_o       = grant_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of the arbitration rules.
module tb_core_mem_arbiter;
  localparam int N = 4;
  localparam int IW = $clog2(N);

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic [IW-1:0] grant;

  core_mem_arbiter_if #(.N_REQ(N)) bus();

  core_mem_arbiter #(.N_REQ(N)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (bus),
    .busy_o  (busy),
    .grant_o (grant)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // model: is a transaction outstanding, for whom, and where the rotation resumes
  bit m_busy;
  int m_grant;
  int m_ptr;

  int dut_log[$];
  logic [N-1:0] obs_rdy;
  bit pend [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int m_pick(input logic [N-1:0] v, input int ptr);
`ifdef CORE_MEM_ARB_FIXED_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int i = 0; i < N; i++) begin
      int k;
      k = (ptr + i) % N;
`ifdef CORE_MEM_ARB_FIXED_PRIO_EN
      if (k != 0 && v[k]) return k;
`else
      if (v[k]) return k;
`endif
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_grant = 0; m_ptr = 0;
  endtask

  // Check all outputs mid-cycle against the model, then advance model and clock.
  task automatic cycle();
    bit done;
    int p;
    @(negedge clk);
    done = m_busy && bus.mem_rdy && !rst;
    chk("busy_o",    32'(busy),          32'(m_busy));
    chk("grant_o",   32'(grant),         32'(m_grant));
    chk("mem_val",   32'(bus.mem_val),   32'(m_busy));
    chk("mem_wen",   32'(bus.mem_wen),   m_busy ? 32'(bus.req_wen[m_grant]) : 32'd0);
    chk("mem_addr",  32'(bus.mem_addr),  m_busy ? 32'(bus.req_addr[8*m_grant +: 8]) : 32'd0);
    chk("mem_wdata", 32'(bus.mem_wdata), m_busy ? 32'(bus.req_wdata[16*m_grant +: 16]) : 32'd0);
    chk("req_rdy",   32'(bus.req_rdy),   done ? (32'd1 << m_grant) : 32'd0);
    chk("req_rdata", 32'(bus.req_rdata), done ? 32'(bus.mem_rdata) : 32'd0);
    obs_rdy = bus.req_rdy;
    for (int k = 0; k < N; k++) if (bus.req_rdy[k]) dut_log.push_back(k);
    if (rst) model_reset();
    else if (!m_busy) begin
      p = m_pick(bus.req_val, m_ptr);
      if (p >= 0) begin m_busy = 1; m_grant = p; end
    end else if (done) begin
      m_busy = 0;
`ifdef CORE_MEM_ARB_FIXED_PRIO_EN
      if (m_grant != 0) m_ptr = (m_grant + 1) % N;
`else
      m_ptr = (m_grant + 1) % N;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic v, input logic w,
                         input logic [7:0] a, input logic [15:0] d);
    bus.req_val[k]            = v;
    bus.req_wen[k]            = w;
    bus.req_addr[8*k +: 8]    = a;
    bus.req_wdata[16*k +: 16] = d;
  endtask

  task automatic clear_reqs();
    for (int k = 0; k < N; k++) set_req(k, 1'b0, 1'b0, 8'h00, 16'h0000);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.mem_rdy = 1'b0;
    bus.mem_rdata = 16'h0000;
    clear_reqs();
    do_reset();

    // single read from requester 0
    set_req(0, 1'b1, 1'b0, 8'h20, 16'h0000);
    cycle();
    cycle();
    bus.mem_rdy = 1'b1; bus.mem_rdata = 16'hBEEF;
    dut_log.delete();
    cycle();
    chk("t1_rdy_count", 32'(dut_log.size()), 32'd1);
    clear_reqs(); bus.mem_rdy = 1'b0;
    cycle();

    // all four requesting continuously, memory always ready
    do_reset();
    for (int k = 0; k < N; k++) set_req(k, 1'b1, k[0], 8'(8'h10 + k), 16'(16'hA000 + k));
    bus.mem_rdy = 1'b1;
    dut_log.delete();
    repeat (10) cycle();
    chk("t2_grants", 32'(dut_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < dut_log.size(); i++)
`ifdef CORE_MEM_ARB_FIXED_PRIO_EN
      chk("t2_order", 32'(dut_log[i]), 32'd0);
`else
      chk("t2_order", 32'(dut_log[i]), 32'(i % N));
`endif
    clear_reqs(); bus.mem_rdy = 1'b0;
    cycle();

    // wrap: grant 2 leaves the pointer at 3, then 0 and 3 compete
    set_req(2, 1'b1, 1'b0, 8'h42, 16'h0000);
    bus.mem_rdy = 1'b1;
    cycle(); cycle();
    clear_reqs();
    set_req(0, 1'b1, 1'b0, 8'h01, 16'h0000);
    set_req(3, 1'b1, 1'b0, 8'h03, 16'h0000);
    dut_log.delete();
    repeat (4) cycle();
    chk("t3_grants", 32'(dut_log.size()), 32'd2);
`ifdef CORE_MEM_ARB_FIXED_PRIO_EN
    if (dut_log.size() == 2) begin chk("t3_first", 32'(dut_log[0]), 32'd0); chk("t3_second", 32'(dut_log[1]), 32'd0); end
`else
    if (dut_log.size() == 2) begin chk("t3_first", 32'(dut_log[0]), 32'd3); chk("t3_second", 32'(dut_log[1]), 32'd0); end
`endif
    clear_reqs(); bus.mem_rdy = 1'b0;
    cycle();

    // write stall on requester 2
    set_req(2, 1'b1, 1'b1, 8'hFF, 16'h1234);
    dut_log.delete();
    repeat (6) cycle();
    chk("t4_no_early_rdy", 32'(dut_log.size()), 32'd0);
    bus.mem_rdy = 1'b1;
    cycle();
    chk("t4_rdy_once", 32'(dut_log.size()), 32'd1);
    clear_reqs(); bus.mem_rdy = 1'b0;
    cycle();

    // reset mid-transaction, then requester 0 first
    set_req(1, 1'b1, 1'b0, 8'h11, 16'h0000);
    cycle();
    set_req(0, 1'b1, 1'b0, 8'h00, 16'h0000);
    cycle();
    dut_log.delete();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t5_busy_after_rst", 32'(busy), 32'd0);
    chk("t5_grant_after_rst", 32'(grant), 32'd0);
    chk("t5_no_rdy", 32'(dut_log.size()), 32'd0);
    bus.mem_rdy = 1'b1;
    repeat (2) cycle();
    chk("t5_first_served", dut_log.size() > 0 ? 32'(dut_log[0]) : 32'hFFFF_FFFF, 32'd0);
    clear_reqs(); bus.mem_rdy = 1'b0;
    cycle();

    // idle
    repeat (10) cycle();

    // randomized traffic obeying the requester rules
    for (int k = 0; k < N; k++) pend[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (obs_rdy[k]) pend[k] = 0;
        if (!pend[k] && $urandom_range(3) == 0) begin
          pend[k] = 1;
          set_req(k, 1'b1, 1'($urandom), 8'($urandom), 16'($urandom));
        end else if (!pend[k]) begin
          bus.req_val[k] = 1'b0;
        end
      end
      bus.mem_rdy   = ($urandom_range(2) == 0);
      bus.mem_rdata = 16'($urandom);
      rst           = ($urandom_range(150) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
